// File: rtl/timer_pkg.sv
// Shared types and constants for the timer dispatch block.
//   delay_t  : 5-bit delay value carried from the request queue to the timer
//   state_t  : dispatcher FSM state (IDLE / ISSUE / WAIT)
//   WD_LIMIT_DEF : default watchdog limit in cycles for one timer run
package timer_pkg;

  localparam int DELAY_W      = 5;
  localparam int WD_LIMIT_DEF = 40;

  typedef logic [DELAY_W-1:0] delay_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Request queue for the timer dispatcher: DEPTH-entry FIFO of delay values.
//   clk, rst      : clock, synchronous active-high reset
//   push, wr_data : write request (ignored when full)
//   pop, rd_data  : read request (ignored when empty); rd_data shows the head
//   full, empty   : occupancy flags decoded from the level register
//   level         : current occupancy, 0..DEPTH
module dispatch_fifo
  import timer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  delay_t                 wr_data,
  input  logic                   pop,
  output delay_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  delay_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/timer_dispatch.sv
// Timer dispatcher: queues delay requests and feeds them one at a time to a
// downstream timer, guarding each run with a watchdog.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_delay      : delay request offer; accepted when req_ready
//   req_ready                : queue has room (level < DEPTH)
//   tmr_in/tmr_in_valid      : one-cycle load strobe and value to the timer
//   tmr_done                 : timer expiry pulse, honoured only in WAIT
//   done_pulse/err_pulse     : one-cycle completion / watchdog-timeout pulses
//   busy                     : FSM outside IDLE
//   level                    : queue occupancy
module timer_dispatch
  import timer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WD_LIMIT = WD_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  delay_t                 req_delay,
  output logic                   req_ready,
  output delay_t                 tmr_in,
  output logic                   tmr_in_valid,
  input  logic                   tmr_done,
  output logic                   done_pulse,
  output logic                   err_pulse,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_LIMIT);

  state_t          state;
  delay_t          held;
  delay_t          head;
  logic [WD_W-1:0] wd;
  logic [WD_W-1:0] wd_inc;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Ready comes from the registered level only, so a slot freed by a pop
  // becomes visible one cycle later.
  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign wd_inc    = wd + 1'b1;

  dispatch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (req_delay),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      held         <= '0;
      wd           <= '0;
      tmr_in       <= '0;
      tmr_in_valid <= 1'b0;
      done_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      tmr_in_valid <= 1'b0;
      done_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            held <= head;
            // A zero delay completes on the spot; the timer never sees it.
            if (head == '0) begin
              done_pulse <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          tmr_in_valid <= 1'b1;
          tmr_in       <= held;
          wd           <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          wd <= (wd == WD_LIM) ? wd : wd_inc;
          // tmr_done takes priority over a watchdog expiry on the same edge.
          if (tmr_done) begin
            done_pulse <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (wd_inc >= WD_LIM) begin
            err_pulse <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dispatch.sv
// Scoreboard bench for timer_dispatch. Stimulus queues the expected events
// (issue with value, done, err) together with the cycle they should appear;
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_timer_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [4:0] req_delay = '0;
  logic       tmr_done = 1'b0;
  logic       req_ready;
  logic [4:0] tmr_in;
  logic       tmr_in_valid;
  logic       done_pulse;
  logic       err_pulse;
  logic       busy;
  logic [2:0] level;

  always #5 clk = ~clk;

  timer_dispatch #(.DEPTH(4), .WD_LIMIT(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_delay    (req_delay),
    .req_ready    (req_ready),
    .tmr_in       (tmr_in),
    .tmr_in_valid (tmr_in_valid),
    .tmr_done     (tmr_done),
    .done_pulse   (done_pulse),
    .err_pulse    (err_pulse),
    .busy         (busy),
    .level        (level)
  );

  // kind: 0 = timer issue, 1 = done, 2 = err; cyc < 0 means any cycle
  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d, want none (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == 0) chk("issue_value", val, e.val);
      if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (tmr_in_valid === 1'b1) check_ev(0, int'(tmr_in));
    if (done_pulse === 1'b1)   check_ev(1, 0);
    if (err_pulse === 1'b1)    check_ev(2, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    req_valid = 1'b1;
    req_delay = 5'(d);
    step();
    req_valid = 1'b0;
  endtask

  // Wait for the next load strobe, then answer it two cycles later.
  task automatic serve();
    int n = 0;
    while (tmr_in_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL serve_timeout: got no tmr_in_valid, want one within 100 cycles");
    end
    step();
    step();
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    int k;
    int m;
    int v[6];
    v = '{31, 3, 7, 1, 9, 12};

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tmr_in", int'(tmr_in), 0);
    chk("rst_tmr_in_valid", int'(tmr_in_valid), 0);
    chk("rst_done", int'(done_pulse), 0);
    chk("rst_err", int'(err_pulse), 0);
    rst = 1'b0;
    step();

    // Single request of 5, answered 6 cycles after the load
    k = cyc;
    expect_ev(0, 5, k + 3);
    expect_ev(1, 0, k + 9);
    push(5);
    while (cyc < k + 8) step();
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
    chk("single_busy_after_done", int'(busy), 0);
    chk("single_level", int'(level), 0);

    // Blocker 31 keeps the FSM in WAIT while 3,7,1,9 fill the queue; 12 drops
    step();
    k = cyc;
    expect_ev(0, 31, k + 3);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        chk("full_ready", int'(req_ready), 0);
        chk("full_level", int'(level), 4);
      end
      req_valid = 1'b1;
      req_delay = 5'(v[i]);
      step();
    end
    req_valid = 1'b0;
    chk("dropped_level", int'(level), 4);

    // Release blocker; offer 13 in the pop cycle (rejected) and the next one
    m = cyc;
    expect_ev(1, 0, m + 1);
    expect_ev(0, 3, m + 3);
    expect_ev(1, 0, -1);
    expect_ev(0, 7, -1);
    expect_ev(1, 0, -1);
    expect_ev(0, 1, -1);
    expect_ev(1, 0, -1);
    expect_ev(0, 9, -1);
    expect_ev(1, 0, -1);
    expect_ev(0, 13, -1);
    expect_ev(1, 0, -1);
    tmr_done = 1'b1;
    step();
    tmr_done  = 1'b0;
    req_valid = 1'b1;
    req_delay = 5'd13;
    chk("collide_ready", int'(req_ready), 0);
    chk("collide_level", int'(level), 4);
    step();
    chk("after_pop_ready", int'(req_ready), 1);
    chk("after_pop_level", int'(level), 3);
    step();
    req_valid = 1'b0;
    chk("refill_level", int'(level), 4);
    for (int i = 0; i < 5; i++) serve();

    // Zero delay completes without a load; tmr_in keeps its last value
    step();
    k = cyc;
    expect_ev(1, 0, k + 2);
    push(0);
    step();
    chk("zero_tmr_in_hold", int'(tmr_in), 13);
    chk("zero_busy", int'(busy), 0);
    chk("zero_level", int'(level), 0);
    k = cyc;
    expect_ev(0, 4, k + 3);
    expect_ev(1, 0, -1);
    push(4);
    serve();

    // Watchdog: 8 never answered, err 40 cycles after the load
    step();
    k = cyc;
    expect_ev(0, 8, k + 3);
    expect_ev(2, 0, k + 43);
    push(8);
    while (cyc < k + 45) step();
    chk("wd_busy", int'(busy), 0);

    // tmr_done on the watchdog-limit edge wins
    k = cyc;
    expect_ev(0, 6, k + 3);
    expect_ev(1, 0, k + 43);
    push(6);
    while (cyc < k + 42) step();
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
    step();
    chk("tie_busy", int'(busy), 0);

    // tmr_done in IDLE and in ISSUE is ignored
    k = cyc;
    expect_ev(0, 2, k + 3);
    expect_ev(1, 0, k + 6);
    tmr_done  = 1'b1;
    req_valid = 1'b1;
    req_delay = 5'd2;
    step();
    req_valid = 1'b0;
    tmr_done  = 1'b0;
    step();
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
    step();
    step();
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
    step();

    // Reset during WAIT for 2 with 6 and 10 queued
    k = cyc;
    expect_ev(0, 2, k + 3);
    push(2);
    push(6);
    push(10);
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_level", int'(level), 0);
    chk("midrst_ready", int'(req_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tmr_in", int'(tmr_in), 0);
    rst      = 1'b0;
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
    repeat (5) step();
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_level", int'(level), 0);

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
